hazard_ctrl: RTL

Pipeline hazard controller for the five-stage RISC-V core. It keeps a shadow pipeline of destination tags for E, M and W, and detects load-use and taken-branch hazards. From these it drives the stall/flush controls for the fetch, decode and execute pipeline registers, and the execute-stage forwarding selects. It also keeps saturating stall and flush event counters for performance debug. It sits beside `decode_cycle`/`execute_cycle`, takes the decode-stage register fields and the execute-stage branch outcome, and sequences the whole pipeline.

---
 rtl/hazard_ctrl_if.sv | 27 ++
 rtl/hazard_ctrl.sv | 72 +++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: decode/execute hazard signals between the pipeline (master) and hazard_ctrl (slave)
interface hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0]       Rs1D;
  logic [4:0]       Rs2D;
  logic [4:0]       RdD;
  logic             RegWriteD;
  logic             ResultSrcD;
  logic             UsesRs1D;
  logic             UsesRs2D;
  logic             PCSrcE;
  logic             StallF;
  logic             StallD;
  logic             FlushD;
  logic             FlushE;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;
  modport master (
    output Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, UsesRs1D, UsesRs2D, PCSrcE,
    input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, StallCount, FlushCount
  );
  modport slave (
    input  Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, UsesRs1D, UsesRs2D, PCSrcE,
    output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, StallCount, FlushCount
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use/branch hazard detection, stall/flush control, forwarding selects and event counters
// Ports: clk, rst (async, active-high); hz (slave) carries decode fields and PCSrcE in,
// StallF/StallD/FlushD/FlushE, ForwardAE/ForwardBE and saturating StallCount/FlushCount out.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input logic        clk,
  input logic        rst,
  hazard_ctrl_if.slave hz
);
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       load;
  } stage_t;
  stage_t           e_q, e_d, m_q, m_d, w_q, w_d;
  logic             valid_d_q, valid_d_d;
  logic [4:0]       rs1_e_q, rs1_e_d, rs2_e_q, rs2_e_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             lu, br, stall, flush_e;
  // M is checked first so the youngest producer wins; x0 never forwards
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input stage_t m, input stage_t w);
    fwd_sel = (m.valid & m.reg_write & (|m.rd) & (m.rd == rs)) ? 2'b10 :
              (w.valid & w.reg_write & (|w.rd) & (w.rd == rs)) ? 2'b01 : 2'b00;
  endfunction
  always_comb begin
    lu = valid_d_q & e_q.valid & e_q.load & (|e_q.rd) &
         ((hz.UsesRs1D & (hz.Rs1D == e_q.rd)) | (hz.UsesRs2D & (hz.Rs2D == e_q.rd)));
    br = e_q.valid & hz.PCSrcE;
    stall = lu & ~br;
    flush_e = br | lu;
    w_d = m_q;
    m_d = e_q;
    e_d = flush_e ? {1'b0, e_q.rd, e_q.reg_write, e_q.load} :
                    {valid_d_q, hz.RdD, hz.RegWriteD, hz.ResultSrcD};
    rs1_e_d = flush_e ? rs1_e_q : hz.Rs1D;
    rs2_e_d = flush_e ? rs2_e_q : hz.Rs2D;
    valid_d_d = br ? 1'b0 : stall ? valid_d_q : 1'b1;
    stall_cnt_d = (stall & ~&stall_cnt_q) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = (br & ~&flush_cnt_q) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_d_q   <= 1'b0;
      e_q         <= '0;
      m_q         <= '0;
      w_q         <= '0;
      rs1_e_q     <= '0;
      rs2_e_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      valid_d_q   <= valid_d_d;
      e_q         <= e_d;
      m_q         <= m_d;
      w_q         <= w_d;
      rs1_e_q     <= rs1_e_d;
      rs2_e_q     <= rs2_e_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign hz.StallF     = stall;
  assign hz.StallD     = stall;
  assign hz.FlushD     = br;
  assign hz.FlushE     = flush_e;
  assign hz.ForwardAE  = fwd_sel(rs1_e_q, m_q, w_q);
  assign hz.ForwardBE  = fwd_sel(rs2_e_q, m_q, w_q);
  assign hz.StallCount = stall_cnt_q;
  assign hz.FlushCount = flush_cnt_q;
endmodule
